alu_op_chord_enc: RTL and testbench

//  Sequential, parametrised successor to the calculator's combinational button encoder.
//  - Synchronises and debounces NUM_BTN raw push-buttons.
//  - Collects a multi-button chord inside a time window and encodes it to an ALU opcode.
//  - Issues the opcode exactly once per press over a valid/ready handshake to the calculator datapath.

---
 rtl/alu_enc_pkg.sv | 40 ++++
 rtl/btn_debounce.sv | 51 +++++
 rtl/alu_op_chord_enc.sv | 150 +++++++++++++++
 tb/tb_alu_op_chord_enc.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_enc_pkg.sv
// Shared types and helpers for the chord-to-opcode button encoder.
// Holds the FSM state type, the 3-button opcode table, the encode function
// and the counter-width helpers used to size the timing counters.
package alu_enc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    ISSUE,
    RELEASE
  } enc_state_t;

  // Opcode table for the 3-button calculator, indexed by the chord {L,R,D}.
  // The all-zero entry exists only to complete the table. A chord of zero
  // never reaches the issue stage.
  localparam logic [3:0] OP_TABLE [8] = '{
    4'b0000, 4'b0001, 4'b0100, 4'b0101,
    4'b0110, 4'b1010, 4'b1011, 4'b1100
  };

  // Number of bits needed for a counter that runs 0 .. max_count-1.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

  localparam int unsigned DEF_DEBOUNCE_W = cnt_width(16);
  localparam int unsigned DEF_CHORD_W    = cnt_width(32);
  localparam int unsigned DEF_REPEAT_W   = cnt_width(4096);

  // A 3-button chord goes through the table. Any other button count passes
  // the chord through unchanged. The caller sizes the result to its opcode width.
  function automatic logic [31:0] chord_to_op(input logic [31:0] chord,
                                              input int unsigned num_btn);
    logic [31:0] result;
    result = chord;
    if (num_btn == 3) result = 32'(OP_TABLE[chord[2:0]]);
    return result;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: a two-flop synchroniser followed by a stability counter.
// 'press' pulses for one cycle, in the same cycle that 'level' rises.
module btn_debounce
  import alu_enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYC);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous raw level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Flip the level only after DEBOUNCE_CYC disagreeing cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else if (sync_q2 == level) begin
      cnt   <= '0;
      press <= 1'b0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
      cnt   <= '0;
      level <= sync_q2;
      press <= sync_q2;
    end else begin
      cnt   <= cnt + CNT_W'(1);
      press <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_chord_enc.sv
// Chord encoder: debounces NUM_BTN buttons and collects a chord inside a
// window that opens at the first press. It then issues one opcode over a
// valid/ready handshake.
// Optional feature: define ALU_ENC_REPEAT_EN to re-issue the op every
// REPEAT_CYC cycles while the whole chord stays held.
module alu_op_chord_enc
  import alu_enc_pkg::*;
#(
  parameter int unsigned NUM_BTN      = 3,
  parameter int unsigned OP_W         = 4,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned CHORD_CYC    = 32,
  parameter int unsigned REPEAT_CYC   = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [OP_W-1:0]    op,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [NUM_BTN-1:0] chord,
  output logic               busy
);

  localparam int unsigned WIN_W = cnt_width(CHORD_CYC);

  typedef logic [OP_W-1:0]    op_t;
  typedef logic [NUM_BTN-1:0] btn_t;

  if (DEBOUNCE_CYC < 2 || CHORD_CYC < 1 || REPEAT_CYC < 2) begin : g_param_check
    $error("alu_op_chord_enc: timing parameter out of range");
  end

  btn_t             levels;
  btn_t             presses;
  enc_state_t       state;
  enc_state_t       state_n;
  btn_t             chord_n;
  op_t              op_n;
  logic             op_valid_n;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_cnt_n;

`ifdef ALU_ENC_REPEAT_EN
  localparam int unsigned REP_W = cnt_width(REPEAT_CYC);
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_cnt_n;
  logic             rep_live;
  logic             rep_live_n;
`endif

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btn_raw[gi]),
      .level  (levels[gi]),
      .press  (presses[gi])
    );
  end

  assign busy = (state != IDLE);

  // Next state, chord accumulation, opcode capture and handshake.
  always_comb begin
    state_n    = state;
    chord_n    = chord;
    op_n       = op;
    op_valid_n = op_valid;
    win_cnt_n  = win_cnt;
`ifdef ALU_ENC_REPEAT_EN
    rep_cnt_n  = rep_cnt;
    rep_live_n = rep_live;
`endif
    unique case (state)
      IDLE: begin
        if (|presses) begin
          state_n   = COLLECT;
          chord_n   = presses;
          win_cnt_n = '0;
        end
      end
      COLLECT: begin
        chord_n   = chord | presses;
        win_cnt_n = win_cnt + WIN_W'(1);
        if (win_cnt == WIN_W'(CHORD_CYC - 1)) begin
          state_n    = ISSUE;
          op_n       = op_t'(chord_to_op(32'(chord_n), NUM_BTN));
          op_valid_n = 1'b1;
        end
      end
      ISSUE: begin
        if (op_ready) begin
          state_n    = RELEASE;
          op_valid_n = 1'b0;
`ifdef ALU_ENC_REPEAT_EN
          rep_cnt_n  = '0;
          rep_live_n = 1'b1;
`endif
        end
      end
      RELEASE: begin
        if (levels == '0) begin
          state_n = IDLE;
        end
`ifdef ALU_ENC_REPEAT_EN
        else if (rep_live) begin
          if ((levels & chord) != chord) begin
            rep_live_n = 1'b0;
          end else if (rep_cnt == REP_W'(REPEAT_CYC - 2)) begin
            state_n    = ISSUE;
            op_valid_n = 1'b1;
          end else begin
            rep_cnt_n = rep_cnt + REP_W'(1);
          end
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs. All of them clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      chord    <= '0;
      op       <= '0;
      op_valid <= 1'b0;
      win_cnt  <= '0;
`ifdef ALU_ENC_REPEAT_EN
      rep_cnt  <= '0;
      rep_live <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      chord    <= chord_n;
      op       <= op_n;
      op_valid <= op_valid_n;
      win_cnt  <= win_cnt_n;
`ifdef ALU_ENC_REPEAT_EN
      rep_cnt  <= rep_cnt_n;
      rep_live <= rep_live_n;
`endif
    end
  end

endmodule

// File: tb/tb_alu_op_chord_enc.sv
// Bench for alu_op_chord_enc with small timing parameters.
// Expected values come from the chord rules: which buttons land inside the
// window, the opcode table, and the fixed delay from a stable raw press.
// The bench is also correct when ALU_ENC_REPEAT_EN is defined.
module tb_alu_op_chord_enc;

  localparam int NB = 3;
  localparam int OW = 4;
  localparam int DB = 4;
  localparam int CC = 8;
  localparam int RC = 64;

  // Raw level first driven at cycle c. It passes 2 synchroniser flops and
  // DB stable cycles, and becomes the debounced press at c+2+DB. op_valid
  // then appears CC+1 cycles after that press.
  localparam int LAT = 3 + DB + CC;

`ifdef ALU_ENC_REPEAT_EN
  localparam int EXP_REPEAT_OPS = 3;
`else
  localparam int EXP_REPEAT_OPS = 1;
`endif

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [NB-1:0] btn_raw  = '0;
  logic          op_ready = 1'b0;
  logic [OW-1:0] op;
  logic          op_valid;
  logic [NB-1:0] chord;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [3:0] op_model [8] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB, 4'hC};

  logic [3:0] xfer_op[$];
  logic [2:0] xfer_chord[$];
  int         xfer_cyc[$];
  int         rise_cyc[$];
  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic [3:0] prev_op    = '0;

  alu_op_chord_enc #(
    .NUM_BTN     (NB),
    .OP_W        (OW),
    .DEBOUNCE_CYC(DB),
    .CHORD_CYC   (CC),
    .REPEAT_CYC  (RC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .op      (op),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .chord   (chord),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge. It observes the handshake, then drives the
  // next inputs and moves on to the next falling edge.
  task automatic applyStimulus(input logic [2:0] raw, input logic rdy);
    if (prev_hs) checkOutput("valid_drop_after_accept", 32'(op_valid), 32'(0));
    else if (op_valid && prev_valid) checkOutput("op_stable_while_valid", 32'(op), 32'(prev_op));
    if (op_valid && !prev_valid) rise_cyc.push_back(cyc);
    btn_raw = raw;
    op_ready = rdy;
    prev_hs = op_valid && rdy;
    if (prev_hs) begin
      xfer_op.push_back(op);
      xfer_chord.push_back(chord);
      xfer_cyc.push_back(cyc);
    end
    prev_valid = op_valid;
    prev_op = op;
    @(negedge clk);
  endtask

  // Each button rises at its own offset, after an optional short bounce.
  // All buttons are released 10 cycles after the op is accepted.
  task automatic runTrial(input string name, input logic [2:0] mask,
                          input int off0, input int off1, input int off2,
                          input bit bounce, input int rdy_on);
    int off[3];
    int first;
    int rel_t;
    int c_first;
    int nx0;
    int nr0;
    logic [2:0] raw;
    logic [2:0] incl;
    off = '{off0, off1, off2};
    first = 1000;
    for (int i = 0; i < 3; i++) if (mask[i] && off[i] < first) first = off[i];
    incl = '0;
    for (int i = 0; i < 3; i++) if (mask[i] && (off[i] - first) <= CC) incl[i] = 1'b1;
    nx0 = xfer_op.size();
    nr0 = rise_cyc.size();
    rel_t = 120;
    c_first = 0;
    for (int t = 0; t < rel_t + DB + 8; t++) begin
      raw = '0;
      for (int i = 0; i < 3; i++) begin
        if (mask[i] && t < rel_t) begin
          if (t >= 4 + off[i]) raw[i] = 1'b1;
          else if (bounce && (t == off[i] || t == off[i] + 2)) raw[i] = 1'b1;
        end
      end
      if (t == 4 + first) c_first = cyc;
      applyStimulus(raw, t >= rdy_on);
      if (rel_t == 120 && xfer_op.size() > nx0) rel_t = t + 10;
    end
    checkOutput({name, "_op_count"}, 32'(xfer_op.size() - nx0), 32'(1));
    if (xfer_op.size() > nx0) begin
      checkOutput({name, "_op"}, 32'(xfer_op[nx0]), 32'(op_model[incl]));
      checkOutput({name, "_chord"}, 32'(xfer_chord[nx0]), 32'(incl));
    end
    if (rise_cyc.size() > nr0)
      checkOutput({name, "_latency"}, 32'(rise_cyc[nr0] - c_first), 32'(LAT));
    checkOutput({name, "_idle_after_release"}, 32'(busy), 32'(0));
  endtask

  initial begin
    logic [2:0] mask;
    int o[3];
    int fb;
    int nx0;
    int nr0;
    int c0;
    int b;
    int len;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("reset_op", 32'(op), 32'(0));
    checkOutput("reset_op_valid", 32'(op_valid), 32'(0));
    checkOutput("reset_chord", 32'(chord), 32'(0));
    checkOutput("reset_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    applyStimulus(3'b000, 1'b0);

    $display("[TB] directed chords");
    runTrial("d_alone_bounce", 3'b001, 0, 0, 0, 1'b1, 0);
    runTrial("l_then_r5", 3'b110, 0, 5, 0, 1'b0, 0);
    runTrial("l_then_r10", 3'b110, 0, 10, 0, 1'b0, 0);
    runTrial("all_ready_late", 3'b111, 0, 0, 0, 1'b0, 45);

    $display("[TB] random chords");
    for (int k = 0; k < 12; k++) begin
      mask = 3'($urandom_range(1, 7));
      fb = mask[0] ? 0 : (mask[1] ? 1 : 2);
      for (int i = 0; i < 3; i++)
        o[i] = (i == fb) ? 0 :
               ($urandom_range(0, 1) == 1 ? int'($urandom_range(0, CC - 1))
                                          : int'($urandom_range(CC + 2, CC + 5)));
      runTrial("rand", mask, o[0], o[1], o[2], 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 40)));
    end

    $display("[TB] glitches");
    nr0 = rise_cyc.size();
    for (int k = 0; k < 20; k++) begin
      b = int'($urandom_range(0, 2));
      len = int'($urandom_range(1, DB - 1));
      for (int j = 0; j < len; j++) begin
        applyStimulus(3'(1 << b), 1'b0);
        checkOutput("glitch_busy", 32'(busy), 32'(0));
      end
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        applyStimulus(3'b000, 1'b0);
        checkOutput("glitch_busy", 32'(busy), 32'(0));
      end
    end
    repeat (DB + 4) applyStimulus(3'b000, 1'b0);
    checkOutput("glitch_no_op", 32'(rise_cyc.size() - nr0), 32'(0));

    $display("[TB] reset during issue");
    for (int t = 0; t < 60 && !op_valid; t++) applyStimulus(3'b010, 1'b0);
    checkOutput("rst_pre_valid", 32'(op_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_op", 32'(op), 32'(0));
    checkOutput("rst_mid_op_valid", 32'(op_valid), 32'(0));
    checkOutput("rst_mid_chord", 32'(chord), 32'(0));
    checkOutput("rst_mid_busy", 32'(busy), 32'(0));
    applyStimulus(3'b010, 1'b0);
    applyStimulus(3'b010, 1'b0);
    rst_n = 1'b1;
    c0 = cyc;
    nx0 = xfer_op.size();
    nr0 = rise_cyc.size();
    for (int t = 0; t < 60 && xfer_op.size() == nx0; t++) applyStimulus(3'b010, 1'b1);
    checkOutput("rst_reissue_count", 32'(xfer_op.size() - nx0), 32'(1));
    if (xfer_op.size() > nx0) checkOutput("rst_reissue_op", 32'(xfer_op[nx0]), 32'(4'b0100));
    if (rise_cyc.size() > nr0)
      checkOutput("rst_reissue_latency", 32'(rise_cyc[nr0] - c0), 32'(LAT));
    repeat (DB + 8) applyStimulus(3'b000, 1'b0);
    checkOutput("rst_idle_after_release", 32'(busy), 32'(0));

    $display("[TB] long hold");
    nx0 = xfer_op.size();
    c0 = cyc;
    for (int t = 0; t < 180; t++) applyStimulus(3'b010, 1'b1);
    repeat (DB + 16) applyStimulus(3'b000, 1'b0);
    checkOutput("hold_op_count", 32'(xfer_op.size() - nx0), 32'(EXP_REPEAT_OPS));
    if (xfer_op.size() > nx0)
      checkOutput("hold_first_latency", 32'(xfer_cyc[nx0] - c0), 32'(LAT));
    for (int k = nx0; k < xfer_op.size(); k++) begin
      checkOutput("hold_op", 32'(xfer_op[k]), 32'(4'b0100));
      if (k > nx0) checkOutput("hold_period", 32'(xfer_cyc[k] - xfer_cyc[k - 1]), 32'(RC));
    end
    checkOutput("hold_idle_after_release", 32'(busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
